// File: rtl/wb_master_port.sv
// Wishbone B4 classic single-access initiator: one valid/ready request in, one bus cycle out, one-cycle response strobe back.
// Optional build macro WB_MASTER_ERR_EN adds the wbm_err_i bus-error input.
module wb_master_port #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TCNT_W         = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_sel,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_dat,
  output logic        rsp_valid,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        busy,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
`ifdef WB_MASTER_ERR_EN
  ,
  input  logic        wbm_err_i
`endif
);

  typedef enum logic {IDLE, BUS} state_t;

  state_t            state, state_nxt;
  logic [TCNT_W-1:0] tcnt, tcnt_nxt;
  logic              cyc_nxt, we_nxt, rsp_valid_nxt, rsp_err_nxt;
  logic [3:0]        sel_nxt;
  logic [31:0]       adr_nxt, dat_nxt, rsp_dat_nxt;
  logic              bus_err;
  logic              timeout_hit;

`ifdef WB_MASTER_ERR_EN
  assign bus_err = wbm_err_i;
`else
  assign bus_err = 1'b0;
`endif

  // Counter holds the number of completed stb cycles; the edge ending stb cycle N fires when N == TIMEOUT_CYCLES.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt == TCNT_W'(TIMEOUT_CYCLES - 1));

  assign req_ready = (state == IDLE);
  assign busy      = (state == BUS);
  assign wbm_stb_o = wbm_cyc_o;

  always_comb begin
    state_nxt     = state;
    tcnt_nxt      = tcnt;
    cyc_nxt       = wbm_cyc_o;
    we_nxt        = wbm_we_o;
    sel_nxt       = wbm_sel_o;
    adr_nxt       = wbm_adr_o;
    dat_nxt       = wbm_dat_o;
    rsp_valid_nxt = 1'b0;
    rsp_err_nxt   = 1'b0;
    rsp_dat_nxt   = '0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          we_nxt    = req_we;
          sel_nxt   = req_sel;
          adr_nxt   = req_adr;
          dat_nxt   = req_dat;
          cyc_nxt   = 1'b1;
          tcnt_nxt  = '0;
          state_nxt = BUS;
        end
      end
      BUS: begin
        if (bus_err) begin
          cyc_nxt       = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b1;
          state_nxt     = IDLE;
        end else if (wbm_ack_i) begin
          cyc_nxt       = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_dat_nxt   = wbm_we_o ? '0 : wbm_dat_i;
          state_nxt     = IDLE;
        end else if (timeout_hit) begin
          cyc_nxt       = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b1;
          state_nxt     = IDLE;
        end else begin
          tcnt_nxt = tcnt + TCNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      tcnt      <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_dat   <= '0;
    end else begin
      state     <= state_nxt;
      tcnt      <= tcnt_nxt;
      wbm_cyc_o <= cyc_nxt;
      wbm_we_o  <= we_nxt;
      wbm_sel_o <= sel_nxt;
      wbm_adr_o <= adr_nxt;
      wbm_dat_o <= dat_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_err   <= rsp_err_nxt;
      rsp_dat   <= rsp_dat_nxt;
    end
  end

endmodule
